// File: rtl/vrf_port_release_unit.sv
// vrf_port_release_unit
//   Closes the loop of the vector resource allocation stage. On each accepted
//   allocation, every granted VRF read/write port is loaded with the
//   instruction's vector length. Lane beats count that length down on each
//   port. When a port's work is done, the unit emits a one-cycle free pulse so
//   the allocator can hand the port out again.
//
// Ports
//   clk, rstn                  clock, synchronous active-low reset
//   alloc_vld_i / alloc_rdy_o  allocation handshake (rdy = !flush_i)
//   r_port_en_i, w_port_en_i   ports granted by the current allocation
//   vl_i                       beats each granted port must service
//   r_beat_i, w_beat_i         per-port beat strobes from the lanes
//   flush_i                    abort all outstanding work
//   free_r_port_o/free_w_port_o  one-cycle release pulses per port
//   r_busy_o, w_busy_o         port is tracked (BUSY or RELEASE)
//   alloc_err_o                sticky: allocation hit a non-IDLE port
module vrf_port_release_unit #(
  parameter int unsigned R_PORTS_NUM = 8,
  parameter int unsigned W_PORTS_NUM = 4,
  parameter int unsigned VL_WIDTH    = 12
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   alloc_vld_i,
  output logic                   alloc_rdy_o,
  input  logic [R_PORTS_NUM-1:0] r_port_en_i,
  input  logic [W_PORTS_NUM-1:0] w_port_en_i,
  input  logic [VL_WIDTH-1:0]    vl_i,
  input  logic [R_PORTS_NUM-1:0] r_beat_i,
  input  logic [W_PORTS_NUM-1:0] w_beat_i,
  input  logic                   flush_i,
  output logic [R_PORTS_NUM-1:0] free_r_port_o,
  output logic [W_PORTS_NUM-1:0] free_w_port_o,
  output logic [R_PORTS_NUM-1:0] r_busy_o,
  output logic [W_PORTS_NUM-1:0] w_busy_o,
  output logic                   alloc_err_o
);

  // Read and write ports behave identically, so they are tracked as one
  // flat vector: read ports in the low bits, write ports above them.
  localparam int unsigned P_NUM = R_PORTS_NUM + W_PORTS_NUM;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RELEASE
  } port_state_e;

  port_state_e         state_q [P_NUM];
  port_state_e         state_d [P_NUM];
  logic [VL_WIDTH-1:0] cnt_q   [P_NUM];
  logic [VL_WIDTH-1:0] cnt_d   [P_NUM];
  logic                err_q;
  logic                err_d;

  logic [P_NUM-1:0]    en_all;
  logic [P_NUM-1:0]    beat_all;
  logic [P_NUM-1:0]    free_all;
  logic [P_NUM-1:0]    busy_all;
  logic                accept;

  assign alloc_rdy_o = !flush_i;
  assign accept      = alloc_vld_i && alloc_rdy_o;
  assign en_all      = {w_port_en_i, r_port_en_i};
  assign beat_all    = {w_beat_i, r_beat_i};

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < P_NUM; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < P_NUM; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      err_q <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    err_d = err_q;
    for (int unsigned i = 0; i < P_NUM; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_IDLE: begin
          if (accept && en_all[i]) begin
            if (vl_i != '0) begin
              cnt_d[i]   = vl_i;
              state_d[i] = ST_BUSY;
            end else begin
              state_d[i] = ST_RELEASE;
            end
          end
        end
        ST_BUSY: begin
          // Flush takes priority over a same-cycle beat; accept is already
          // low under flush, so no grant can collide here either.
          if (flush_i) begin
            cnt_d[i]   = '0;
            state_d[i] = ST_RELEASE;
          end else begin
            if (accept && en_all[i]) begin
              err_d = 1'b1;
            end
            if (beat_all[i]) begin
              if (cnt_q[i] == VL_WIDTH'(1)) begin
                cnt_d[i]   = '0;
                state_d[i] = ST_RELEASE;
              end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - VL_WIDTH'(1);
              end
            end
          end
        end
        ST_RELEASE: begin
          state_d[i] = ST_IDLE;
          if (accept && en_all[i]) begin
            err_d = 1'b1;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Output decode from registered state
  always_comb begin
    free_all = '0;
    busy_all = '0;
    for (int unsigned i = 0; i < P_NUM; i++) begin
      free_all[i] = (state_q[i] == ST_RELEASE);
      busy_all[i] = (state_q[i] != ST_IDLE);
    end
  end

  assign free_r_port_o = free_all[R_PORTS_NUM-1:0];
  assign free_w_port_o = free_all[P_NUM-1:R_PORTS_NUM];
  assign r_busy_o      = busy_all[R_PORTS_NUM-1:0];
  assign w_busy_o      = busy_all[P_NUM-1:R_PORTS_NUM];
  assign alloc_err_o   = err_q;

endmodule

// File: tb/tb_vrf_port_release_unit.sv
module tb_vrf_port_release_unit;

  localparam int R = 8;
  localparam int W = 4;
  localparam int P = R + W;
  localparam int VLW = 12;

  logic           clk = 1'b0;
  logic           rstn;
  logic           alloc_vld_i;
  logic           alloc_rdy_o;
  logic [R-1:0]   r_port_en_i;
  logic [W-1:0]   w_port_en_i;
  logic [VLW-1:0] vl_i;
  logic [R-1:0]   r_beat_i;
  logic [W-1:0]   w_beat_i;
  logic           flush_i;
  logic [R-1:0]   free_r_port_o;
  logic [W-1:0]   free_w_port_o;
  logic [R-1:0]   r_busy_o;
  logic [W-1:0]   w_busy_o;
  logic           alloc_err_o;

  vrf_port_release_unit #(
    .R_PORTS_NUM(R),
    .W_PORTS_NUM(W),
    .VL_WIDTH(VLW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .alloc_vld_i(alloc_vld_i),
    .alloc_rdy_o(alloc_rdy_o),
    .r_port_en_i(r_port_en_i),
    .w_port_en_i(w_port_en_i),
    .vl_i(vl_i),
    .r_beat_i(r_beat_i),
    .w_beat_i(w_beat_i),
    .flush_i(flush_i),
    .free_r_port_o(free_r_port_o),
    .free_w_port_o(free_w_port_o),
    .r_busy_o(r_busy_o),
    .w_busy_o(w_busy_o),
    .alloc_err_o(alloc_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [P-1:0] free;
    logic [P-1:0] busy;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: per port, "has outstanding work" plus beats left,
  // and a pending release that shows up as the next cycle's free pulse.
  bit act  [P];
  int left [P];
  bit pend [P];
  bit err_m;

  task automatic model_step(input bit rn, input bit vld, input bit fl,
                            input logic [P-1:0] en, input logic [P-1:0] beat,
                            input int vl, output exp_t e);
    bit nact [P];
    int nleft [P];
    bit npend [P];
    bit acc;
    acc = vld && !fl;
    for (int p = 0; p < P; p++) begin
      nact[p] = act[p];
      nleft[p] = left[p];
      npend[p] = 1'b0;
      if (!rn) begin
        nact[p] = 1'b0;
        nleft[p] = 0;
      end else begin
        if (act[p]) begin
          if (fl) begin
            nact[p] = 1'b0;
            npend[p] = 1'b1;
          end else if (beat[p]) begin
            nleft[p] = left[p] - 1;
            if (nleft[p] == 0) begin
              nact[p] = 1'b0;
              npend[p] = 1'b1;
            end
          end
        end
        if (acc && en[p]) begin
          if (act[p] || pend[p]) err_m = 1'b1;
          else if (vl == 0) npend[p] = 1'b1;
          else begin
            nact[p] = 1'b1;
            nleft[p] = vl;
          end
        end
      end
    end
    if (!rn) err_m = 1'b0;
    for (int p = 0; p < P; p++) begin
      act[p] = nact[p];
      left[p] = nleft[p];
      pend[p] = npend[p];
      e.free[p] = npend[p];
      e.busy[p] = nact[p] | npend[p];
    end
    e.err = err_m;
  endtask

  // Drive one cycle of inputs (called at negedge), check the combinational
  // ready, and queue the outputs expected after the next rising edge.
  task automatic step(input bit rn, input bit vld, input bit fl,
                      input logic [P-1:0] en, input logic [P-1:0] beat,
                      input int vl);
    exp_t e;
    rstn = rn;
    alloc_vld_i = vld;
    flush_i = fl;
    {w_port_en_i, r_port_en_i} = en;
    {w_beat_i, r_beat_i} = beat;
    vl_i = VLW'(vl);
    #1;
    total++;
    if (alloc_rdy_o !== !fl) begin
      bad++;
      $display("FAIL alloc_rdy got=%0b exp=%0b t=%0t", alloc_rdy_o, !fl, $time);
    end
    model_step(rn, vld, fl, en, beat, vl, e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, '0, '0, 0);
  endtask

  // Monitor: after each rising edge, compare DUT outputs with the oldest
  // queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if ({free_w_port_o, free_r_port_o} !== e.free) begin
          bad++;
          $display("FAIL free got=%b exp=%b t=%0t", {free_w_port_o, free_r_port_o}, e.free, $time);
        end
        total++;
        if ({w_busy_o, r_busy_o} !== e.busy) begin
          bad++;
          $display("FAIL busy got=%b exp=%b t=%0t", {w_busy_o, r_busy_o}, e.busy, $time);
        end
        total++;
        if (alloc_err_o !== e.err) begin
          bad++;
          $display("FAIL alloc_err got=%0b exp=%0b t=%0t", alloc_err_o, e.err, $time);
        end
      end
    end
  end

  initial begin
    logic [P-1:0] en;
    logic [P-1:0] bt;
    err_m = 1'b0;
    for (int p = 0; p < P; p++) begin
      act[p] = 1'b0;
      left[p] = 0;
      pend[p] = 1'b0;
    end

    // Reset
    step(1'b0, 1'b0, 1'b0, '0, '0, 0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 0);

    // r0,r1,w0 with vl=3, three beats each
    step(1'b1, 1'b1, 1'b0, {4'b0001, 8'b0000_0011}, '0, 3);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, '0, {4'b0001, 8'b0000_0011}, 0);
    idle(3);

    // vl=0 on w2: release without beats
    step(1'b1, 1'b1, 1'b0, {4'b0100, 8'h00}, '0, 0);
    idle(3);

    // Allocation collision on busy r0, r2 still loaded
    step(1'b1, 1'b1, 1'b0, {4'b0000, 8'b0000_0001}, '0, 4);
    step(1'b1, 1'b0, 1'b0, '0, {4'b0000, 8'b0000_0001}, 0);
    step(1'b1, 1'b1, 1'b0, {4'b0000, 8'b0000_0101}, '0, 2);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, '0, {4'b0000, 8'b0000_0101}, 0);
    idle(3);

    // Reset clears sticky error
    step(1'b0, 1'b0, 1'b0, '0, '0, 0);
    idle(1);

    // Flush with same-cycle beat; alloc offered during flush is refused
    step(1'b1, 1'b1, 1'b0, {4'b0000, 8'b0000_0001}, '0, 5);
    step(1'b1, 1'b1, 1'b0, {4'b0000, 8'b0000_0010}, '0, 2);
    step(1'b1, 1'b1, 1'b1, {4'b0000, 8'b0001_0000}, {4'b0000, 8'b0000_0010}, 3);
    idle(3);

    // w3: final beat, free, then re-allocate the cycle after the free
    step(1'b1, 1'b1, 1'b0, {4'b1000, 8'h00}, '0, 1);
    step(1'b1, 1'b0, 1'b0, '0, {4'b1000, 8'h00}, 0);
    idle(1);
    step(1'b1, 1'b1, 1'b0, {4'b1000, 8'h00}, '0, 1);
    step(1'b1, 1'b0, 1'b0, '0, {4'b1000, 8'h00}, 0);
    idle(2);

    // Reset while busy: no free pulses afterwards
    step(1'b1, 1'b1, 1'b0, {4'b0011, 8'b1100_0000}, '0, 6);
    step(1'b1, 1'b1, 1'b0, {4'b0011, 8'h00}, '0, 2);
    step(1'b0, 1'b0, 1'b0, '0, '0, 0);
    idle(3);

    // Max vector length, counted all the way down
    step(1'b1, 1'b1, 1'b0, {4'b0000, 8'b1000_0000}, '0, 4095);
    for (int k = 0; k < 4095; k++) step(1'b1, 1'b0, 1'b0, '0, {4'b0000, 8'b1000_0000}, 0);
    idle(2);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      en = P'($urandom & $urandom & $urandom);
      bt = P'($urandom | $urandom);
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 39) == 0), en, bt,
           ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 6)));
    end
    idle(2);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d exp=0 pending expectations", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
